tech_pll_mc: RTL
================

# tech_pll_mc

Parametrised multi-channel behavioural PLL model for simulation and FPGA prototyping. It derives NCH divided clocks from a single input clock and runs a lock sequence before any output toggles. It accepts runtime divider reconfiguration, which forces a relock, and flags loss of lock. The block sits where the SoC clock tree instantiates its technology PLL; for ASIC tape-out it is replaced by a hard macro with the same ports.

## Interface
- NCH, 2: number of output clock channels, ≥1
- DIV_WIDTH, 8: divider field width per channel, ≥1
- LOCK_CYCLES, 16: clk_i cycles spent in LOCKING, ≥2
- clk_i  in  1  reference clock, sole clock of the block
- rst_n_i  in  1  reset, synchronous, active-low
- en_i  in  1  PLL enable; low forces power-down state
- cfg_valid_i  in  1  new divider configuration valid
- cfg_ready_o  out  1  configuration can be accepted this cycle
- cfg_div_i  in  NCH*DIV_WIDTH  divider value per channel, channel n in bits [n*DIV_WIDTH +: DIV_WIDTH]
- lock_o  out  1  high while LOCKED
- lock_lost_o  out  1  one-cycle pulse when leaving LOCKED
- clk_o  out  NCH  divided clocks, 50% duty

## Operation
- Clocking: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- States: IDLE, LOCKING, LOCKED. All state, counters and outputs are registered.
- Reset: state IDLE, divider registers 0, lock counter 0, channel counters 0, lock_o=0, lock_lost_o=0, clk_o=0.
- IDLE:
  - clk_o held 0, channel counters held 0.
  - en_i=1 moves to LOCKING with the lock counter cleared.
- LOCKING:
  - clk_o held 0.
  - The lock counter increments each cycle; at count LOCK_CYCLES-1 the block moves to LOCKED.
- LOCKED:
  - Each channel n runs a DIV_WIDTH-bit counter against its divider value d.
  - If cnt==d: cnt←0 and clk_o[n] toggles. Otherwise cnt←cnt+1.
  - Output period is 2*(d+1) clk_i cycles. d=0 gives divide-by-2; d=2^DIV_WIDTH-1 is the maximum, and the counter never overflows.
- en_i=0 in any state moves to IDLE next cycle. This priority holds over every other transition.
- Configuration handshake:
  - cfg_ready_o=1 in IDLE and LOCKED, 0 in LOCKING.
  - The transfer occurs when cfg_valid_i && cfg_ready_o; the divider registers latch cfg_div_i.
  - In IDLE the transfer only latches the values.
  - In LOCKED (with en_i=1) the transfer moves to LOCKING. Lock counter, channel counters and clk_o clear, so there is no glitch or partial period at the old divisor.
- Simultaneous transfer and en_i=0: the divider values are latched and the state goes to IDLE.
- lock_lost_o pulses for exactly one cycle on any LOCKED→IDLE or LOCKED→LOCKING transition. It does not pulse on reset.
- Reset asserted mid-operation (any state) returns all registers to reset values on that edge; lock_lost_o stays 0.

## Timing
- en_i sampled high at edge E0 (from IDLE, no cfg activity):
  - LOCKING from E0.
  - LOCKED and lock_o=1 after edge E_LOCK_CYCLES.
  - First clk_o[n] rising edge after edge E_(LOCK_CYCLES+d+1).
- A reconfiguration accepted at edge R gives lock_o=0 and lock_lost_o=1 after R, and lock_o=1 again after R+LOCK_CYCLES.
- en_i sampled low at edge D gives lock_o=0 and clk_o=0 after D.
- cfg_ready_o depends on state only; there is no combinational path from inputs.
- All outputs change only on clk_i rising edges.

## Test plan
- Reset then en_i=1, cfg_div default 0, NCH=2, LOCK_CYCLES=16 -> lock_o rises exactly 16 cycles after en_i sampled; both clk_o toggle every cycle (period 2); cfg_ready_o=0 during those 16 cycles.
- In IDLE write cfg_div={ch1=3, ch0=1}, then enable -> after lock, clk_o[0] period 4 and clk_o[1] period 8, both 50% duty, first rise at lock+2 and lock+4 cycles respectively.
- While LOCKED, write ch0=5 -> next cycle lock_o=0, lock_lost_o high for one cycle, clk_o=0; relock after 16 cycles; clk_o[0] period 12.
- Hold cfg_valid_i=1 during LOCKING -> no transfer until LOCKED; the transfer then triggers a second relock.
- Deassert en_i in LOCKING and in LOCKED, including in the same cycle as a cfg transfer -> state IDLE next cycle; lock_lost_o pulses only for the LOCKED case; new divisors take effect after re-enable.
- Pull rst_n_i low for 1 cycle while LOCKED with div=255 -> all outputs 0 next cycle, dividers reset to 0, lock_lost_o remains 0.

Source files
------------

// File: rtl/tech_pll_mc.sv
// Behavioural multi-channel PLL: lock sequence, then NCH divided clocks.
// Divider reconfiguration while locked forces a clean relock.
module tech_pll_mc #(
  parameter int NCH         = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [NCH*DIV_WIDTH-1:0] cfg_div_i,
  output logic                     lock_o,
  output logic                     lock_lost_o,
  output logic [NCH-1:0]           clk_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOCKING,
    LOCKED
  } state_t;

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  state_t                   state;
  state_t                   next_state;
  logic [LCW-1:0]           lock_cnt;
  logic [NCH*DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0]     ch_cnt [NCH];
  logic                     cfg_fire;
  logic                     run_div;

  assign cfg_ready_o = (state != LOCKING);
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign run_div     = (state == LOCKED) && (next_state == LOCKED);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Disable outranks every other transition, including a pending transfer.
  always_comb begin
    next_state = state;
    if (!en_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = LOCKING;
        LOCKING: if (lock_cnt == LOCK_LAST) next_state = LOCKED;
        LOCKED:  if (cfg_fire) next_state = LOCKING;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_cnt    <= '0;
      div_q       <= '0;
      lock_o      <= 1'b0;
      lock_lost_o <= 1'b0;
      clk_o       <= '0;
      for (int n = 0; n < NCH; n++) begin
        ch_cnt[n] <= '0;
      end
    end else begin
      if ((state == LOCKING) && (next_state == LOCKING)) begin
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end

      if (cfg_fire) begin
        div_q <= cfg_div_i;
      end

      lock_o      <= (next_state == LOCKED);
      lock_lost_o <= (state == LOCKED) && (next_state != LOCKED);

      // Leaving LOCKED clears counters so a relock starts with a full period.
      for (int n = 0; n < NCH; n++) begin
        if (run_div) begin
          if (ch_cnt[n] == div_q[n*DIV_WIDTH +: DIV_WIDTH]) begin
            ch_cnt[n] <= '0;
            clk_o[n]  <= ~clk_o[n];
          end else begin
            ch_cnt[n] <= ch_cnt[n] + 1'b1;
          end
        end else begin
          ch_cnt[n] <= '0;
          clk_o[n]  <= 1'b0;
        end
      end
    end
  end

endmodule
